// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DEF_WIDTH = 4;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_nbit_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
// o_ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_nbit_if #(
    parameter int WIDTH = serial_sub_pkg::DEF_WIDTH
) ();

    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             o_ovf;
`endif

    // Requester side: issues operands, observes the result.
    modport master (
        output i_start, i_a, i_b,
`ifdef SERIAL_SUB_OVF_EN
        input  o_ovf,
`endif
        input  o_busy, o_done, o_diff, o_borrow
    );

    // Subtractor side.
    modport slave (
        input  i_start, i_a, i_b,
`ifdef SERIAL_SUB_OVF_EN
        output o_ovf,
`endif
        output o_busy, o_done, o_diff, o_borrow
    );

endinterface : serial_sub_nbit_if

// File: rtl/fs.sv
// 1-bit combinational full subtractor: computes a - b - bin.
module fs (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    // Borrow out when b exceeds a, or when a == b and a borrow is pending.
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule : fs

// File: rtl/serial_sub_nbit.sv
// Bit-serial subtractor: a - b, one bit per clock, LSB first, using one fs cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_nbit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    serial_sub_nbit_if.slave bus
);

    // Wide enough to hold WIDTH-1 without wrapping before the terminal compare.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_b_q, res_q, diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bin_q, borrow_q;
    logic             busy_d, done_d;
    logic             cell_diff, cell_bout;
    logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, b_msb_q, ovf_q;
`endif

    fs u_fs (
        .i_a    (sh_a_q[0]),
        .i_b    (sh_b_q[0]),
        .i_bin  (bin_q),
        .o_diff (cell_diff),
        .o_bout (cell_bout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so requests during RUN/DONE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_start) state_d = S_RUN;
            S_RUN:   if (last_bit)    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            S_RUN:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, serial shift, and result publish on the DONE entry edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        sh_a_q <= bus.i_a;
                        sh_b_q <= bus.i_b;
                        bin_q  <= 1'b0;
                        cnt_q  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= bus.i_a[WIDTH-1];
                        b_msb_q <= bus.i_b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    sh_a_q <= sh_a_q >> 1;
                    sh_b_q <= sh_b_q >> 1;
                    res_q  <= {cell_diff, res_q[WIDTH-1:1]};
                    bin_q  <= cell_bout;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Final bit: publish the completed result directly so it is valid with o_done.
                    if (last_bit) begin
                        diff_q   <= {cell_diff, res_q[WIDTH-1:1]};
                        borrow_q <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q    <= (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy   = busy_d;
    assign bus.o_done   = done_d;
    assign bus.o_diff   = diff_q;
    assign bus.o_borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.o_ovf    = ovf_q;
`endif

endmodule : serial_sub_nbit

// File: tb/tb_serial_sub_nbit.sv
// Self-checking bench for serial_sub_nbit (WIDTH=4); covers SERIAL_SUB_OVF_EN when defined.
module tb_serial_sub_nbit;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_sub_nbit_if #(.WIDTH(W)) bus ();

    serial_sub_nbit #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [31:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return 32'((int'(a) - int'(b)) & ((1 << W) - 1));
    endfunction

    function automatic logic [31:0] ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, r;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        r  = sa - sb;
        return (r > (1 << (W-1)) - 1 || r < -(1 << (W-1))) ? 32'd1 : 32'd0;
    endfunction

    // One full transaction, entered and left at a negedge with the DUT idle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int busy_n = 0;
        int done_n = 0;
        int done_k = 0;
        logic [W-1:0] got_d = '0;
        logic got_b = 1'b0;
        logic got_o = 1'b0;
        bus.i_start = 1'b1;
        bus.i_a = a;
        bus.i_b = b;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_start = 1'b0;
                bus.i_a = W'($urandom);
                bus.i_b = W'($urandom);
            end
            if (bus.o_busy) busy_n++;
            if (bus.o_done) begin
                done_n++;
                done_k = k;
                got_d = bus.o_diff;
                got_b = bus.o_borrow;
`ifdef SERIAL_SUB_OVF_EN
                got_o = bus.o_ovf;
`endif
            end
        end
        $display("op a=%0d b=%0d diff=%0d borrow=%0d ovf=%0d done_at=%0d", a, b, got_d, got_b, got_o, done_k);
        check_val("busy_cycles", busy_n, W);
        check_val("done_pulses", done_n, 1);
        check_val("done_latency", done_k, W + 1);
        check_val("diff", {28'd0, got_d}, ref_diff(a, b));
        check_val("borrow", {31'd0, got_b}, ref_borrow(a, b));
`ifdef SERIAL_SUB_OVF_EN
        check_val("ovf", {31'd0, got_o}, ref_ovf(a, b));
`endif
        check_val("diff_hold", {28'd0, bus.o_diff}, ref_diff(a, b));
    endtask

    initial begin
        int order[256];
        int done_n;
        int done_k[2];
        logic [W-1:0] done_d[2];
        int busy_n;

        bus.i_start = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, bus.o_busy}, 0);
        check_val("rst_done", {31'd0, bus.o_done}, 0);
        check_val("rst_diff", {28'd0, bus.o_diff}, 0);
        check_val("rst_borrow", {31'd0, bus.o_borrow}, 0);
`ifdef SERIAL_SUB_OVF_EN
        check_val("rst_ovf", {31'd0, bus.o_ovf}, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed operations
        do_op(4'd7, 4'd3);
        do_op(4'd3, 4'd7);
        do_op(4'd0, 4'd0);
        do_op(4'd15, 4'd15);
        do_op(4'd0, 4'd1);

        // Start held high through RUN and DONE: only the first op completes until IDLE returns.
        bus.i_start = 1'b1;
        bus.i_a = 4'd9;
        bus.i_b = 4'd2;
        done_n = 0;
        done_k[0] = 0; done_k[1] = 0;
        done_d[0] = '0; done_d[1] = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_a = 4'd1;
                bus.i_b = 4'd1;
            end
            if (k == 7) bus.i_start = 1'b0;
            if (bus.o_done) begin
                if (done_n < 2) begin
                    done_k[done_n] = k;
                    done_d[done_n] = bus.o_diff;
                end
                done_n++;
            end
        end
        $display("hold ops done=%0d first_at=%0d diff=%0d second_at=%0d diff=%0d",
                 done_n, done_k[0], done_d[0], done_k[1], done_d[1]);
        check_val("hold_pulses", done_n, 2);
        check_val("hold_first_at", done_k[0], W + 1);
        check_val("hold_first_diff", {28'd0, done_d[0]}, ref_diff(4'd9, 4'd2));
        check_val("hold_second_at", done_k[1], 2 * W + 3);
        check_val("hold_second_diff", {28'd0, done_d[1]}, ref_diff(4'd1, 4'd1));

        // Leave nonzero results so the reset clearing is visible.
        do_op(4'd3, 4'd7);

        // Reset during the second RUN cycle.
        bus.i_start = 1'b1;
        bus.i_a = 4'd12;
        bus.i_b = 4'd5;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("abort busy=%0d done=%0d diff=%0d borrow=%0d", bus.o_busy, bus.o_done, bus.o_diff, bus.o_borrow);
        check_val("abort_busy", {31'd0, bus.o_busy}, 0);
        check_val("abort_done", {31'd0, bus.o_done}, 0);
        check_val("abort_diff", {28'd0, bus.o_diff}, 0);
        check_val("abort_borrow", {31'd0, bus.o_borrow}, 0);
        done_n = 0;
        busy_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.o_done) done_n++;
            if (bus.o_busy) busy_n++;
        end
        check_val("abort_no_done", done_n, 0);
        check_val("abort_idle", busy_n, 0);
        do_op(4'd12, 4'd5);

        // Signed-overflow cases (ovf checked inside do_op when the feature is built in).
        do_op(4'd7, 4'd15);
        do_op(4'd5, 4'd2);
        do_op(4'd8, 4'd1);

        // Every operand pair, in shuffled order, with random idle gaps.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            logic [7:0] pair;
            pair = 8'(order[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(pair[7:4], pair[3:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_sub_nbit
